// File: rtl/bit_timing_fsm_if.sv
// Bit-timing control bundle: quantum enable, rx line and timing config in, strobes and segment state out.
// Latency: n/a (wires only).
// Backpressure: none; the controller free-runs on Prescale_EN and the consumers must take each strobe.
// Ports: Prescale_EN, rx, hardsync_en, tseg1, tseg2, sjw (master -> slave);
//        sample_pulse, sampled_bit, send_pulse, seg_state (slave -> master).
interface bit_timing_fsm_if #(
    parameter int CNT_W = 4
);
    logic             Prescale_EN;
    logic             rx;
    logic             hardsync_en;
    logic [CNT_W-1:0] tseg1;
    logic [2:0]       tseg2;
    logic [1:0]       sjw;
    logic             sample_pulse;
    logic             sampled_bit;
    logic             send_pulse;
    logic [1:0]       seg_state;

    modport master (
        output Prescale_EN, rx, hardsync_en, tseg1, tseg2, sjw,
        input  sample_pulse, sampled_bit, send_pulse, seg_state
    );

    modport slave (
        input  Prescale_EN, rx, hardsync_en, tseg1, tseg2, sjw,
        output sample_pulse, sampled_bit, send_pulse, seg_state
    );
endinterface

// File: rtl/bit_timing_fsm.sv
// CAN bit-timing controller: sequences SYNC/TSEG1/TSEG2 per quantum with hard sync and SJW-limited resync.
// Latency: strobes are registered, high for one clock after the quantum that produced them.
// Backpressure: none; Prescale_EN=0 freezes all state and forces the strobes low.
// Ports: clock, reset (sync, active low), bus (bit_timing_fsm_if.slave).
// Optional: define TRIPLE_SAMPLE_EN for majority-of-three sampling (tseg1 floor becomes 3).
module bit_timing_fsm #(
    parameter int CNT_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    bit_timing_fsm_if.slave bus
);
    localparam int             PAD = CNT_W - 2;
    localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
`ifdef TRIPLE_SAMPLE_EN
    localparam logic [CNT_W-1:0] TSEG1_MIN = CNT_W'(3);
`else
    localparam logic [CNT_W-1:0] TSEG1_MIN = CNT_W'(2);
`endif

    typedef enum logic [1:0] {
        SYNC  = 2'b00,
        TSEG1 = 2'b01,
        TSEG2 = 2'b10
    } seg_e;

    seg_e           state_q, state_d;
    // One bit wider than tseg1 so the extended TSEG1 (up to 15+4) never wraps.
    logic [CNT_W:0] cnt_q, cnt_d;
    logic [2:0]     ext_q, ext_d;
    logic [2:0]     shr_q, shr_d;
    logic           rd_q, rd_d;
    logic           rx_prev_q;
    logic           sample_q, sample_d;
    logic           send_q, send_d;
    logic           sbit_q, sbit_d;

    logic [CNT_W:0] tseg1_eff, sjw_x, rem;
    logic [2:0]     tseg2_eff, sjw_w, late_ext, ext_cur, shr_cur;
    logic           rx_fall, resync_ok, sample_val, tseg1_end, tseg2_end;

    assign tseg1_eff = {1'b0, (bus.tseg1 < TSEG1_MIN) ? TSEG1_MIN : bus.tseg1};
    assign tseg2_eff = (bus.tseg2 < 3'd2) ? 3'd2 : bus.tseg2;
    assign sjw_w     = {1'b0, bus.sjw} + 3'd1;
    assign sjw_x     = {{PAD{1'b0}}, sjw_w};
    assign rx_fall   = rx_prev_q & ~bus.rx;
    assign resync_ok = rx_fall & ~rd_q;

    // Late edge: phase error equals cnt, clipped to the jump width.
    assign late_ext  = (cnt_q > sjw_x) ? sjw_w : cnt_q[2:0];
    // An edge in this quantum already moves the segment end, so compare against the updated value.
    assign ext_cur   = resync_ok ? late_ext : ext_q;
    assign shr_cur   = resync_ok ? sjw_w : shr_q;
    assign tseg1_end = (cnt_q == tseg1_eff + {{PAD{1'b0}}, ext_cur});
    assign tseg2_end = (cnt_q == {{PAD{1'b0}}, tseg2_eff - shr_cur});
    // Quanta left in TSEG2 including this one; the shortened end can never fall behind cnt.
    assign rem       = {{PAD{1'b0}}, tseg2_eff} - cnt_q + ONE;

`ifdef TRIPLE_SAMPLE_EN
    // rx from the two previous TSEG1 quanta; the current rx is the third vote.
    logic [1:0] hist_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            hist_q <= 2'b11;
        end else if (bus.Prescale_EN) begin
            if (send_d) begin
                hist_q <= 2'b11;
            end else if (state_q == TSEG1) begin
                hist_q <= {hist_q[0], bus.rx};
            end
        end
    end

    assign sample_val = (hist_q[0] & hist_q[1]) | (hist_q[0] & bus.rx) | (hist_q[1] & bus.rx);
`else
    assign sample_val = bus.rx;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ext_d    = ext_q;
        shr_d    = shr_q;
        rd_d     = rd_q;
        sample_d = 1'b0;
        send_d   = 1'b0;
        sbit_d   = sbit_q;

        if (rx_fall && bus.hardsync_en) begin
            // Hard sync: this quantum becomes SYNC, regardless of where we were.
            send_d  = 1'b1;
            state_d = TSEG1;
            cnt_d   = ONE;
            ext_d   = '0;
            shr_d   = '0;
            rd_d    = 1'b1;
        end else begin
            case (state_q)
                SYNC: begin
                    send_d  = 1'b1;
                    state_d = TSEG1;
                    cnt_d   = ONE;
                    ext_d   = '0;
                    shr_d   = '0;
                    rd_d    = 1'b0;
                end
                TSEG1: begin
                    if (resync_ok) begin
                        ext_d = late_ext;
                        rd_d  = 1'b1;
                    end
                    if (tseg1_end) begin
                        sample_d = 1'b1;
                        sbit_d   = sample_val;
                        state_d  = TSEG2;
                        cnt_d    = ONE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                TSEG2: begin
                    if (resync_ok && (rem <= sjw_x)) begin
                        // Early edge within reach: restart the bit here.
                        send_d  = 1'b1;
                        state_d = TSEG1;
                        cnt_d   = ONE;
                        ext_d   = '0;
                        shr_d   = '0;
                        rd_d    = 1'b1;
                    end else begin
                        if (resync_ok) begin
                            shr_d = sjw_w;
                            rd_d  = 1'b1;
                        end
                        if (tseg2_end) begin
                            state_d = SYNC;
                            cnt_d   = ONE;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
                default: begin
                    state_d = SYNC;
                    cnt_d   = ONE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= SYNC;
            cnt_q     <= ONE;
            ext_q     <= '0;
            shr_q     <= '0;
            rd_q      <= 1'b0;
            rx_prev_q <= 1'b1;
            sample_q  <= 1'b0;
            send_q    <= 1'b0;
            sbit_q    <= 1'b1;
        end else if (bus.Prescale_EN) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ext_q     <= ext_d;
            shr_q     <= shr_d;
            rd_q      <= rd_d;
            rx_prev_q <= bus.rx;
            sample_q  <= sample_d;
            send_q    <= send_d;
            sbit_q    <= sbit_d;
        end else begin
            sample_q <= 1'b0;
            send_q   <= 1'b0;
        end
    end

    assign bus.sample_pulse = sample_q;
    assign bus.sampled_bit  = sbit_q;
    assign bus.send_pulse   = send_q;
    assign bus.seg_state    = state_q;
endmodule

// File: tb/tb_bit_timing_fsm.sv
// Bench for bit_timing_fsm: directed bit-timing scenarios with expected strobes queued per scenario.
// Latency: n/a.
// Backpressure: n/a.
module tb_bit_timing_fsm;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    bit_timing_fsm_if #(.CNT_W(4)) bus ();

    bit_timing_fsm #(.CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit         is_sample;
        int         cyc;
        logic       bitv;
        logic [1:0] seg;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  base   = 0;
    bit  mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic check_ev(input bit is_sample);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: strobe at cycle %0d, required none",
                     is_sample ? "sample" : "send", cyc - base);
        end else begin
            e = exp_q.pop_front();
            chk("strobe_kind", 32'(is_sample), 32'(e.is_sample));
            chk("strobe_cycle", cyc - base, e.cyc - base);
            chk("strobe_seg", 32'(bus.seg_state), 32'(e.seg));
            if (is_sample) chk("sampled_bit", 32'(bus.sampled_bit), 32'(e.bitv));
        end
    endtask

    // Strobe monitor, half a clock away from the active edge.
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.send_pulse === 1'b1)   check_ev(1'b0);
            if (bus.sample_pulse === 1'b1) check_ev(1'b1);
        end
    end

    task automatic go(input int k);
        while (cyc < base + k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_ev(input bit s, input int k, input logic b);
        exp_q.push_back('{s, base + k, b, s ? 2'b10 : 2'b01});
    endtask

    task automatic cfg(input int t1, input int t2, input int s, input bit hs);
        bus.tseg1       = 4'(t1);
        bus.tseg2       = 3'(t2);
        bus.sjw         = 2'(s);
        bus.hardsync_en = hs;
        bus.rx          = 1'b1;
        bus.Prescale_EN = 1'b1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_seg_state", 32'(bus.seg_state), 0);
        chk("rst_send_pulse", 32'(bus.send_pulse), 0);
        chk("rst_sample_pulse", 32'(bus.sample_pulse), 0);
        chk("rst_sampled_bit", 32'(bus.sampled_bit), 1);
        reset = 1'b1;
        base  = cyc;
        mon_en = 1'b1;
    endtask

    // Strobes up to cycle k-1 are observed; anything still queued was missed.
    task automatic end_window(input string name, input int k);
        go(k);
        mon_en = 1'b0;
        chk({name, "_missing_strobes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        cfg(5, 3, 0, 1'b0);
        repeat (2) @(posedge clock);
        #1;

        // Nominal bit: 1+5+3 = 9 quanta.
        do_reset();
        expect_ev(0, 1, 1'b1);
        expect_ev(1, 6, 1'b1);
        expect_ev(0, 10, 1'b1);
        expect_ev(1, 15, 1'b1);
        expect_ev(0, 19, 1'b1);
        for (int i = 0; i < 9; i++) begin
            go(9 + i);
            chk("nominal_seg_seq", 32'(bus.seg_state), (i == 0) ? 0 : ((i <= 5) ? 1 : 2));
        end
        end_window("nominal", 21);

        // Late edge in TSEG1 quantum 1, second edge in the same bit ignored.
        cfg(5, 3, 1, 1'b0);
        do_reset();
        expect_ev(0, 1, 1'b1);
        expect_ev(1, 7, 1'b0);
        expect_ev(0, 11, 1'b1);
        expect_ev(1, 16, 1'b1);
        expect_ev(0, 20, 1'b1);
        go(1); bus.rx = 1'b0;
        go(3); bus.rx = 1'b1;
        go(4); bus.rx = 1'b0;
        go(7); bus.rx = 1'b1;
        end_window("late_edge", 21);

        // Early edge in the last TSEG2 quantum: immediate SYNC, 8-quantum bit.
        cfg(5, 3, 1, 1'b0);
        do_reset();
        expect_ev(0, 1, 1'b1);
        expect_ev(1, 6, 1'b1);
        expect_ev(0, 9, 1'b1);
        expect_ev(1, 14, 1'b1);
        expect_ev(0, 18, 1'b1);
        go(8); bus.rx = 1'b0;
        go(9); bus.rx = 1'b1;
        end_window("early_sync", 20);

        // Early edge in TSEG2 quantum 2 of 7, sjw width 1: shortened to a 12-quantum bit.
        cfg(5, 7, 0, 1'b0);
        do_reset();
        expect_ev(0, 1, 1'b1);
        expect_ev(1, 6, 1'b1);
        expect_ev(0, 13, 1'b1);
        expect_ev(1, 18, 1'b1);
        expect_ev(0, 26, 1'b1);
        go(7); bus.rx = 1'b0;
        go(8); bus.rx = 1'b1;
        end_window("early_shorten", 28);

        // Hard sync in TSEG1 quantum 3.
        cfg(5, 3, 0, 1'b1);
        do_reset();
        expect_ev(0, 1, 1'b1);
        expect_ev(0, 4, 1'b1);
        expect_ev(1, 9, 1'b1);
        expect_ev(0, 13, 1'b1);
        go(3); bus.rx = 1'b0;
        go(4);
        chk("hardsync_seg", 32'(bus.seg_state), 1);
        bus.rx = 1'b1;
        bus.hardsync_en = 1'b0;
        end_window("hardsync", 15);

        // One quantum every third clock: 27-clock bit period.
        cfg(5, 3, 0, 1'b0);
        do_reset();
        expect_ev(0, 1, 1'b1);
        expect_ev(1, 16, 1'b1);
        expect_ev(0, 28, 1'b1);
        expect_ev(1, 43, 1'b1);
        expect_ev(0, 55, 1'b1);
        for (int k = 1; k <= 57; k++) begin
            bus.Prescale_EN = (k % 3 == 1);
            go(k);
            if (k == 2 || k == 3 || k == 17 || k == 18)
                chk("prescale_hold_seg", 32'(bus.seg_state), (k < 10) ? 1 : 2);
        end
        bus.Prescale_EN = 1'b1;
        end_window("prescale", 57);

        // Edge in the final TSEG1 quantum extends it; then reset in mid-TSEG2.
        cfg(5, 3, 0, 1'b0);
        do_reset();
        expect_ev(0, 1, 1'b1);
        expect_ev(1, 7, 1'b0);
        go(5); bus.rx = 1'b0;
        go(7); bus.rx = 1'b1;
        end_window("final_q_edge", 8);
        do_reset();
        expect_ev(0, 1, 1'b1);
        end_window("after_reset", 3);

`ifdef TRIPLE_SAMPLE_EN
        // rx = 0,1,0 over the last three TSEG1 quanta.
        cfg(5, 3, 0, 1'b0);
        do_reset();
        expect_ev(0, 1, 1'b1);
        expect_ev(1, 7, 1'b0);
        expect_ev(0, 11, 1'b1);
        go(4); bus.rx = 1'b0;
        go(5); bus.rx = 1'b1;
        go(6); bus.rx = 1'b0;
        go(7); bus.rx = 1'b1;
        end_window("triple_sample", 12);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
